// File: rtl/shot_manager.sv
// Shot table for the asteroids game: spawns shots from the ship, moves them per frame, retires them.
// Define SHOT_WRAP_EN to wrap shots around the screen edges instead of retiring them there.
module shot_manager #(
    parameter int MAX_SHOTS   = 10,
    parameter int ENTITY_SIZE = 34,
    parameter int SHOT_SPEED  = 4,
    parameter int LIFETIME    = 60,
    parameter int COOLDOWN    = 8
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   frame_tick,
    input  logic                                   fire,
    input  logic [ENTITY_SIZE-1:0]                 ship,
    input  logic                                   delete_shot,
    input  logic [9:0]                             shot_address,
    output logic [MAX_SHOTS-1:0][ENTITY_SIZE-1:0]  shots,
    output logic                                   fire_accepted,
    output logic [3:0]                             shot_count
);

    localparam logic [9:0] SPD   = 10'(SHOT_SPEED);
    localparam logic [9:0] X_LIM = 10'd320;
    localparam logic [9:0] Y_LIM = 10'd240;

    logic [MAX_SHOTS-1:0][ENTITY_SIZE-1:0] shots_nxt;
    logic [MAX_SHOTS-1:0]                  free_slots;
    logic [7:0]                            cool_q;
    logic [7:0]                            cool_nxt;
    logic [3:0]                            target;
    logic                                  found;
    logic                                  accept;
    logic [ENTITY_SIZE-1:0]                spawn_word;
    logic                                  unused_ship;

    assign unused_ship = ^{ship[ENTITY_SIZE-1:26], ship[5:3]};
    assign spawn_word  = ENTITY_SIZE'({8'(LIFETIME), ship[25:16], ship[15:6], 2'b00, ship[2:0], 1'b1});

    // One frame of motion for an active slot; returns all-zero when the shot retires.
    function automatic logic [ENTITY_SIZE-1:0] tick_slot(input logic [ENTITY_SIZE-1:0] w);
        logic [2:0] h;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] rem;
        logic       off;
        h   = w[3:1];
        x   = w[15:6];
        y   = w[25:16];
        rem = w[33:26];
        off = 1'b0;
`ifdef SHOT_WRAP_EN
        if (h == 3'd1 || h == 3'd2 || h == 3'd3) x = (x + SPD >= X_LIM) ? x + SPD - X_LIM : x + SPD;
        if (h >= 3'd5)                           x = (x < SPD) ? x + X_LIM - SPD : x - SPD;
        if (h >= 3'd3 && h <= 3'd5)              y = (y + SPD >= Y_LIM) ? y + SPD - Y_LIM : y + SPD;
        if (h == 3'd0 || h == 3'd1 || h == 3'd7) y = (y < SPD) ? y + Y_LIM - SPD : y - SPD;
`else
        if (h == 3'd1 || h == 3'd2 || h == 3'd3) x = x + SPD;
        if (h >= 3'd5)                           x = x - SPD;
        if (h >= 3'd3 && h <= 3'd5)              y = y + SPD;
        if (h == 3'd0 || h == 3'd1 || h == 3'd7) y = y - SPD;
        off = (x >= X_LIM) || (y >= Y_LIM);
`endif
        if (rem == 8'd1 || off)
            tick_slot = '0;
        else
            tick_slot = ENTITY_SIZE'({rem - 8'd1, y, x, 2'b00, h, 1'b1});
    endfunction

    // A slot targeted by a delete this cycle is not offered to a spawn.
    always_comb begin
        free_slots = '0;
        for (int i = 0; i < MAX_SHOTS; i++)
            free_slots[i] = !shots[i][0] && !(delete_shot && shot_address == 10'(i));
    end

    always_comb begin
        found  = 1'b0;
        target = '0;
        for (int i = 0; i < MAX_SHOTS; i++) begin
            if (free_slots[i] && !found) begin
                found  = 1'b1;
                target = 4'(i);
            end
        end
    end

    always_comb begin
        shots_nxt = shots;
        cool_nxt  = cool_q;
        accept    = fire && (cool_q == 8'd0) && found;
        for (int i = 0; i < MAX_SHOTS; i++) begin
            if (delete_shot && shot_address == 10'(i))
                shots_nxt[i] = '0;
            else if (frame_tick && shots[i][0])
                shots_nxt[i] = tick_slot(shots[i]);
            if (accept && target == 4'(i))
                shots_nxt[i] = spawn_word;
        end
        if (accept)
            cool_nxt = 8'(COOLDOWN);
        else if (frame_tick && cool_q != 8'd0)
            cool_nxt = cool_q - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shots         <= '0;
            cool_q        <= '0;
            fire_accepted <= 1'b0;
        end else begin
            shots         <= shots_nxt;
            cool_q        <= cool_nxt;
            fire_accepted <= accept;
        end
    end

    always_comb begin
        shot_count = '0;
        for (int i = 0; i < MAX_SHOTS; i++)
            shot_count = shot_count + {3'b000, shots[i][0]};
    end

endmodule

// File: tb/tb_shot_manager.sv
// Scoreboard bench for shot_manager: a slot-level reference model predicts every cycle's outputs.
module tb_shot_manager;
    localparam int MAX_SHOTS = 10;
    localparam int ES        = 34;
    localparam int SPEED     = 4;
    localparam int LIFE      = 60;
    localparam int COOL      = 3;

    typedef logic [MAX_SHOTS-1:0][ES-1:0] table_t;
    typedef struct {
        table_t tbl;
        int     cnt;
        bit     fa;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          frame_tick;
    logic          fire;
    logic [ES-1:0] ship;
    logic          delete_shot;
    logic [9:0]    shot_address;
    table_t        shots;
    logic          fire_accepted;
    logic [3:0]    shot_count;

    shot_manager #(
        .MAX_SHOTS(MAX_SHOTS), .ENTITY_SIZE(ES), .SHOT_SPEED(SPEED),
        .LIFETIME(LIFE), .COOLDOWN(COOL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .fire(fire), .ship(ship),
        .delete_shot(delete_shot), .shot_address(shot_address), .shots(shots),
        .fire_accepted(fire_accepted), .shot_count(shot_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    bit m_act[MAX_SHOTS];
    int m_h[MAX_SHOTS];
    int m_x[MAX_SHOTS];
    int m_y[MAX_SHOTS];
    int m_rem[MAX_SHOTS];
    int m_cd;
    int sx, sy, sh;
    int dxs[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dys[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    task automatic chk(string name, longint got, longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic model_step(bit rst_n, bit f, bit t, bit d, int a);
        exp_t e;
        bit   acc;
        int   tgt;
        acc = 0;
        if (!rst_n) begin
            foreach (m_act[i]) m_act[i] = 0;
            m_cd = 0;
        end else begin
            tgt = -1;
            for (int i = 0; i < MAX_SHOTS; i++)
                if (tgt < 0 && !m_act[i] && !(d && a == i)) tgt = i;
            acc = f && m_cd == 0 && tgt >= 0;
            for (int i = 0; i < MAX_SHOTS; i++) begin
                if (d && a == i) m_act[i] = 0;
                else if (t && m_act[i]) begin
                    if (m_rem[i] == 1) m_act[i] = 0;
                    else begin
                        m_rem[i]--;
                        m_x[i] += dxs[m_h[i]] * SPEED;
                        m_y[i] += dys[m_h[i]] * SPEED;
`ifdef SHOT_WRAP_EN
                        m_x[i] = (m_x[i] + 320) % 320;
                        m_y[i] = (m_y[i] + 240) % 240;
`else
                        if (m_x[i] < 0 || m_x[i] >= 320 || m_y[i] < 0 || m_y[i] >= 240) m_act[i] = 0;
`endif
                    end
                end
            end
            if (acc) begin
                m_act[tgt] = 1; m_h[tgt] = sh; m_x[tgt] = sx; m_y[tgt] = sy; m_rem[tgt] = LIFE;
            end
            if (acc) m_cd = COOL;
            else if (t && m_cd > 0) m_cd--;
        end
        e.cnt = 0;
        e.fa  = acc;
        for (int i = 0; i < MAX_SHOTS; i++) begin
            e.tbl[i] = '0;
            if (m_act[i]) begin
                e.tbl[i] = {8'(m_rem[i]), 10'(m_y[i]), 10'(m_x[i]), 2'b00, 3'(m_h[i]), 1'b1};
                e.cnt++;
            end
        end
        sb.push_back(e);
    endtask

    task automatic drive(bit rst_n, bit f, bit t, bit d, int a);
        @(negedge clk);
        reset_n      = rst_n;
        fire         = f;
        frame_tick   = t;
        delete_shot  = d;
        shot_address = 10'(a);
        ship = {8'($urandom), 10'(sy), 10'(sx), 3'($urandom), 3'(sh)};
        model_step(rst_n, f, t, d, a);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (shots !== e.tbl) begin
                    errors++;
                    $display("FAIL shots: got %h want %h", shots, e.tbl);
                end
                chk("shot_count", shot_count, e.cnt);
                chk("fire_accepted", fire_accepted, e.fa);
            end
        end
    end

    initial begin : stim
        reset_n = 0; fire = 0; frame_tick = 0; delete_shot = 0; shot_address = 0; ship = '0;
        sx = 0; sy = 0; sh = 0; m_cd = 0;
        foreach (m_act[i]) begin
            m_act[i] = 0; m_h[i] = 0; m_x[i] = 0; m_y[i] = 0; m_rem[i] = 0;
        end

        // reset with fire held
        drive(0, 1, 0, 0, 0);
        settle();
        chk("reset_count", shot_count, 0);
        chk("reset_fa", fire_accepted, 0);
        chk("reset_shots_zero", (shots == '0), 1);
        drive(1, 0, 0, 0, 0);

        // single spawn then one frame
        sx = 100; sy = 50; sh = 2;
        drive(1, 1, 0, 0, 0);
        settle();
        chk("spawn_word", shots[0], {8'd60, 10'd50, 10'd100, 2'b00, 3'd2, 1'b1});
        chk("spawn_pulse", fire_accepted, 1);
        drive(1, 0, 1, 0, 0);
        settle();
        chk("tick_x", shots[0][15:6], 104);
        chk("tick_rem", shots[0][33:26], 59);

        // fill the table with fire held, cooldown spacing
        drive(0, 0, 0, 0, 0);
        sx = 100; sy = 120; sh = 2;
        for (int k = 0; k < 40; k++) begin
            drive(1, 1, 1, 0, 0);
            drive(1, 1, 0, 0, 0);
            drive(1, 1, 0, 0, 0);
        end
        settle();
        chk("full_count", shot_count, 10);
        chk("full_refused", fire_accepted, 0);

        // delete with concurrent fire: slot 5 vacated first, then delete 3 + fire
        sx = 10; sy = 20; sh = 4;
        drive(1, 0, 0, 1, 5);
        drive(1, 1, 0, 1, 3);
        settle();
        chk("del_slot3_clear", shots[3], 0);
        chk("del_spawn_slot5_x", shots[5][15:6], 10);
        chk("del_spawn_slot5_act", shots[5][0], 1);
        drive(1, 0, 0, 1, 12);
        settle();
        chk("del_oob_count", shot_count, 9);

        // lifetime expiry, heading +y from the top edge
        drive(0, 0, 0, 0, 0);
        sx = 160; sy = 0; sh = 4;
        drive(1, 1, 0, 0, 0);
        for (int k = 0; k < 59; k++) begin
            drive(1, 0, 1, 0, 0);
            drive(1, 0, 0, 0, 0);
        end
        settle();
        chk("life_y_last", shots[0][25:16], 236);
        chk("life_alive", shot_count, 1);
        drive(1, 0, 1, 0, 0);
        settle();
        chk("life_expired", shot_count, 0);

        // left edge crossing
        drive(0, 0, 0, 0, 0);
        sx = 2; sy = 100; sh = 6;
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        settle();
`ifdef SHOT_WRAP_EN
        chk("edge_wrap_x", shots[0][15:6], 318);
`else
        chk("edge_clear", shot_count, 0);
`endif

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            sx = $urandom_range(0, 319);
            sy = $urandom_range(0, 239);
            sh = $urandom_range(0, 7);
            drive(($urandom_range(0, 399) != 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  $urandom_range(0, 15));
        end

        drive(1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
